reservation_station_pool: RTL and testbench
===========================================

# reservation_station_pool

Multi-entry, parametrised successor to the single-entry reservation station. It holds up to DEPTH issued operations for one functional unit and tracks each operand until it is resolved, capturing results from N_BCAST broadcast channels. The oldest entry whose operands are both resolved is dispatched to the unit over a valid/ready handshake. The block sits between the issue stage and its functional unit; entries are freed by retirement.

## Interface
Parameters:
- DATA_WIDTH, 64, operand/result width
- DEPTH, 4, number of entries (≥2, power of two)
- N_BCAST, 2, broadcast channels
- RS_ID, ALU, e_functional_unit owning this pool

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- issue_en_i  in  1  issue request
- issue_op_i  in  operation_specification  operation to enqueue
- read1_value_i, read2_value_i  in  tagged_register  operand value or producer tag
- full_o  out  1  no free entry
- issue_tag_o  out  rs_tag  tag to be assigned by an issue this cycle (valid when !full_o)
- bcast_en_i  in  N_BCAST  per-channel valid
- bcast_tag_i  in  N_BCAST × rs_tag  producer tag
- bcast_data_i  in  N_BCAST × DATA_WIDTH  result value
- disp_valid_o  out  1  dispatch offer
- disp_ready_i  in  1  unit accepts
- disp_slot_o  out  $clog2(DEPTH)  slot being dispatched
- disp_op_o  out  operation_specification  operation
- disp_op1_o, disp_op2_o  out  DATA_WIDTH  resolved operands
- unit_done_i  in  1  unit completed an op
- done_slot_i  in  $clog2(DEPTH)  slot completed
- retire_i  in  1  retire request
- retire_slot_i  in  $clog2(DEPTH)  slot to free
- done_mask_o  out  DEPTH  entries awaiting retirement
- busy_mask_o  out  DEPTH  entries not FREE

## Operation
- Per-entry state: FREE → WAIT (any operand unresolved) → READY → EXEC → DONE → FREE.
- Issue: when issue_en_i && !full_o, the lowest-index FREE slot is allocated. issue_tag_o = {RS_ID, that slot}. An issue while full_o is ignored; no state change.
- Operand capture at issue: a non-virtual operand is stored resolved. A virtual operand stores the tag, unresolved, unless a same-cycle broadcast matches it, in which case the broadcast data is captured (bypass).
- Broadcast: every unresolved operand in WAIT whose tag equals an enabled channel's tag captures that data. If several channels match, the lowest channel wins. Broadcasts to non-WAIT entries are ignored. An entry moves WAIT→READY once both operands are resolved.
- Dispatch selection: among READY entries, pick the oldest by issue order, tracked with a DEPTH×DEPTH age matrix.
  - Once disp_valid_o is asserted and not accepted, the selection is locked. The same slot and payload are held until disp_ready_i.
  - On a handshake the entry goes READY→EXEC.
- unit_done_i with done_slot_i moves that slot EXEC→DONE. If the slot is not in EXEC, the request is ignored.
- retire_i with retire_slot_i moves that slot DONE→FREE. If the slot is not in DONE, the request is ignored.
- Reset: all entries FREE, age matrix cleared. full_o=0, disp_valid_o=0, done_mask_o=0, busy_mask_o=0, issue_tag_o={RS_ID,0}, data outputs 0.

## Timing
- full_o, issue_tag_o, disp_*_o, and both masks are decoded from registered state only. There are no combinational paths from any input to these outputs.
- Issue with both operands resolved at edge N: disp_valid_o for that entry can be high in cycle N+1.
- Broadcast at edge N resolving the last operand: dispatch is possible in cycle N+1.
- Retire and issue in the same cycle while full: the issue is ignored. The freed slot becomes available in the following cycle.
- Dispatch handshake and unit_done_i for the same slot in the same cycle: done is ignored, because the slot is not yet in EXEC.
- Asynchronous reset mid-operation drops all entries immediately. No partial dispatch survives.

## Structure
- types package additions:
  - rs_tag {e_functional_unit unit; logic [RS_SLOT_W-1:0] slot}
  - tagged_register (is_virtual, union of value / rs_tag)
  - e_rs_entry_state
  - RS_SLOT_W
- One sub-module, rs_age_matrix: tracks relative age of entries, set on allocate, cleared on free. It outputs a one-hot oldest-of-mask given a request mask.
- The top level contains the per-entry state, operand capture, and handshake logic.

## Test plan
- Four issues of resolved operands (op1=5, op2=7) with disp_ready_i held low: full_o=1 after the 4th. A 5th issue is ignored. Raising ready dispatches slots 0,1,2,3 in order.
- Issue slot0 waiting on tag {MUL,2}; at the same edge, bcast ch1 {MUL,2} data 0xAB: the entry enters READY with op1=0xAB, and disp_valid_o is high at N+1.
- Broadcast on ch0 and ch1 with the same tag, data 1 and 2: the operand captures 1.
- Slot2 ready and offered with ready low; older slot1 then becomes READY: disp_slot_o stays 2 until accepted, then 1 is dispatched.
- Full pool with retire_i slot3 and issue_en_i in the same cycle: the issue is ignored; the next cycle's issue gets tag slot 3.
- Reset asserted while 3 entries are in EXEC: all masks are 0 and disp_valid_o=0 immediately. A late unit_done_i after reset is ignored.

Source files
------------

// File: rtl/reservation_station_pool_pkg.sv
// Shared types for the reservation station pool.
//   rs_tag            : producer identity {functional unit, slot}
//   tagged_register   : operand as read from the register file; either a
//                       value or the tag of the producer still computing it
//   e_rs_entry_state  : lifecycle of one pool entry
//   RS_SLOT_W         : slot field width inside rs_tag (covers pools up to 16)
package reservation_station_pool_pkg;

    localparam int RS_DATA_W = 64;
    localparam int RS_SLOT_W = 4;

    typedef enum logic [1:0] {
        ALU = 2'd0,
        MUL = 2'd1,
        LSU = 2'd2,
        BRU = 2'd3
    } e_functional_unit;

    typedef struct packed {
        e_functional_unit       unit;
        logic [RS_SLOT_W-1:0]   slot;
    } rs_tag;

    localparam int RS_TAG_W = $bits(rs_tag);

    // The tag overlays the low bits of the value field.
    typedef union packed {
        logic [RS_DATA_W-1:0] value;
        struct packed {
            logic [RS_DATA_W-RS_TAG_W-1:0] pad;
            rs_tag                         tag;
        } prod;
    } operand_u;

    typedef struct packed {
        logic     is_virtual;
        operand_u data;
    } tagged_register;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rd;
        logic [4:0] rob_id;
    } operation_specification;

    typedef enum logic [2:0] {
        RS_FREE  = 3'd0,
        RS_WAIT  = 3'd1,
        RS_READY = 3'd2,
        RS_EXEC  = 3'd3,
        RS_DONE  = 3'd4
    } e_rs_entry_state;

    function automatic rs_tag make_tag(e_functional_unit unit, logic [RS_SLOT_W-1:0] slot);
        rs_tag t;
        t.unit = unit;
        t.slot = slot;
        return t;
    endfunction

endpackage

// File: rtl/reservation_station_pool_age_matrix.sv
// rs_age_matrix: relative issue age of the pool entries.
//   clk, rst             : clock, async active-high reset
//   alloc_en/alloc_slot  : entry being allocated this cycle (becomes youngest)
//   free_en/free_slot    : entry being freed this cycle (forgets its ordering)
//   req                  : candidate entries
//   oldest               : one-hot oldest entry among req (0 when req is 0)
// age_q[r][c] = 1 means entry r was allocated before entry c.
module rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_en,
    input  logic [$clog2(DEPTH)-1:0] alloc_slot,
    input  logic                     free_en,
    input  logic [$clog2(DEPTH)-1:0] free_slot,
    input  logic [DEPTH-1:0]         req,
    output logic [DEPTH-1:0]         oldest
);
    localparam int SLOT_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DEPTH-1:0] age_q;

    // Allocation marks every other row as older than the new entry and clears
    // the new entry's own row. Rows/columns of free entries may hold stale 1s
    // for the allocation column, but free entries never request and their row
    // is rewritten when they are allocated. Free clears take priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                for (int c = 0; c < DEPTH; c++) begin
                    if (free_en && (free_slot == SLOT_W'(r) || free_slot == SLOT_W'(c)))
                        age_q[r][c] <= 1'b0;
                    else if (alloc_en && alloc_slot == SLOT_W'(c) && r != c)
                        age_q[r][c] <= 1'b1;
                    else if (alloc_en && alloc_slot == SLOT_W'(r))
                        age_q[r][c] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < DEPTH; c++) begin
            oldest[c] = req[c];
            for (int r = 0; r < DEPTH; r++)
                if (req[r] && age_q[r][c])
                    oldest[c] = 1'b0;
        end
    end

endmodule

// File: rtl/reservation_station_pool.sv
// reservation_station_pool: DEPTH-entry reservation station for one unit.
//   issue_*      : enqueue an operation with two tagged operands; full_o and
//                  issue_tag_o tell the issue stage where it will land
//   bcast_*      : N_BCAST result channels captured by waiting operands
//   disp_*       : valid/ready offer of the oldest READY entry
//   unit_done_i  : unit finished the op in done_slot_i (EXEC -> DONE)
//   retire_i     : free retire_slot_i (DONE -> FREE)
//   done_mask_o  : entries in DONE; busy_mask_o: entries not FREE
// All outputs are decoded from registered state only.
module reservation_station_pool
    import reservation_station_pool_pkg::*;
#(
    parameter int               DATA_WIDTH = 64,
    parameter int               DEPTH      = 4,
    parameter int               N_BCAST    = 2,
    parameter e_functional_unit RS_ID      = ALU
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   issue_en_i,
    input  operation_specification                 issue_op_i,
    input  tagged_register                         read1_value_i,
    input  tagged_register                         read2_value_i,
    output logic                                   full_o,
    output rs_tag                                  issue_tag_o,
    input  logic [N_BCAST-1:0]                     bcast_en_i,
    input  rs_tag [N_BCAST-1:0]                    bcast_tag_i,
    input  logic [N_BCAST-1:0][DATA_WIDTH-1:0]     bcast_data_i,
    output logic                                   disp_valid_o,
    input  logic                                   disp_ready_i,
    output logic [$clog2(DEPTH)-1:0]               disp_slot_o,
    output operation_specification                 disp_op_o,
    output logic [DATA_WIDTH-1:0]                  disp_op1_o,
    output logic [DATA_WIDTH-1:0]                  disp_op2_o,
    input  logic                                   unit_done_i,
    input  logic [$clog2(DEPTH)-1:0]               done_slot_i,
    input  logic                                   retire_i,
    input  logic [$clog2(DEPTH)-1:0]               retire_slot_i,
    output logic [DEPTH-1:0]                       done_mask_o,
    output logic [DEPTH-1:0]                       busy_mask_o
);
    localparam int SLOT_W = $clog2(DEPTH);

    e_rs_entry_state        state_q [DEPTH];
    operation_specification op_q    [DEPTH];
    logic [DATA_WIDTH-1:0]  v1_q    [DEPTH];
    logic [DATA_WIDTH-1:0]  v2_q    [DEPTH];
    rs_tag                  t1_q    [DEPTH];
    rs_tag                  t2_q    [DEPTH];
    logic [DEPTH-1:0]       r1_q, r2_q;
    logic                   locked_q;
    logic [SLOT_W-1:0]      locked_slot_q;

    // {hit, data}; the lowest matching channel wins.
    function automatic logic [DATA_WIDTH:0] lookup(
        input rs_tag                               t,
        input logic [N_BCAST-1:0]                  en,
        input rs_tag [N_BCAST-1:0]                 tags,
        input logic [N_BCAST-1:0][DATA_WIDTH-1:0]  data
    );
        logic [DATA_WIDTH:0] r;
        r = '0;
        for (int c = N_BCAST - 1; c >= 0; c--)
            if (en[c] && tags[c] == t)
                r = {1'b1, data[c]};
        return r;
    endfunction

    // ---------------- status decode ----------------
    logic [DEPTH-1:0]  free_mask, ready_mask, oldest;
    logic [SLOT_W-1:0] free_slot, oldest_slot, sel_slot;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            free_mask[i]   = (state_q[i] == RS_FREE);
            ready_mask[i]  = (state_q[i] == RS_READY);
            done_mask_o[i] = (state_q[i] == RS_DONE);
            busy_mask_o[i] = (state_q[i] != RS_FREE);
        end
    end

    always_comb begin
        free_slot = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (free_mask[i])
                free_slot = SLOT_W'(i);
    end

    always_comb begin
        oldest_slot = '0;
        for (int i = 0; i < DEPTH; i++)
            if (oldest[i])
                oldest_slot = SLOT_W'(i);
    end

    assign full_o      = ~|free_mask;
    assign issue_tag_o = make_tag(RS_ID, RS_SLOT_W'(free_slot));

    // A refused offer stays on the same slot until it is taken, even if an
    // older entry becomes READY meanwhile.
    assign disp_valid_o = locked_q | (|ready_mask);
    assign sel_slot     = locked_q ? locked_slot_q : oldest_slot;
    assign disp_slot_o  = sel_slot;
    assign disp_op_o    = disp_valid_o ? op_q[sel_slot] : '0;
    assign disp_op1_o   = disp_valid_o ? v1_q[sel_slot] : '0;
    assign disp_op2_o   = disp_valid_o ? v2_q[sel_slot] : '0;

    logic issue_fire, handshake, free_en;
    assign issue_fire = issue_en_i && !full_o;
    assign handshake  = disp_valid_o && disp_ready_i;
    assign free_en    = retire_i && (state_q[retire_slot_i] == RS_DONE);

    // ---------------- operand capture ----------------
    logic [DATA_WIDTH:0]   iss_lk1, iss_lk2;
    logic                  iss_r1, iss_r2;
    logic [DATA_WIDTH-1:0] iss_v1, iss_v2;

    assign iss_lk1 = lookup(read1_value_i.data.prod.tag, bcast_en_i, bcast_tag_i, bcast_data_i);
    assign iss_lk2 = lookup(read2_value_i.data.prod.tag, bcast_en_i, bcast_tag_i, bcast_data_i);
    assign iss_r1  = !read1_value_i.is_virtual || iss_lk1[DATA_WIDTH];
    assign iss_r2  = !read2_value_i.is_virtual || iss_lk2[DATA_WIDTH];
    assign iss_v1  = read1_value_i.is_virtual ? iss_lk1[DATA_WIDTH-1:0] : read1_value_i.data.value;
    assign iss_v2  = read2_value_i.is_virtual ? iss_lk2[DATA_WIDTH-1:0] : read2_value_i.data.value;

    logic [DATA_WIDTH:0]   lk1 [DEPTH];
    logic [DATA_WIDTH:0]   lk2 [DEPTH];
    logic [DEPTH-1:0]      w_r1, w_r2;
    logic [DATA_WIDTH-1:0] w_v1 [DEPTH];
    logic [DATA_WIDTH-1:0] w_v2 [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign lk1[g]  = lookup(t1_q[g], bcast_en_i, bcast_tag_i, bcast_data_i);
        assign lk2[g]  = lookup(t2_q[g], bcast_en_i, bcast_tag_i, bcast_data_i);
        assign w_r1[g] = r1_q[g] | lk1[g][DATA_WIDTH];
        assign w_r2[g] = r2_q[g] | lk2[g][DATA_WIDTH];
        assign w_v1[g] = (!r1_q[g] && lk1[g][DATA_WIDTH]) ? lk1[g][DATA_WIDTH-1:0] : v1_q[g];
        assign w_v2[g] = (!r2_q[g] && lk2[g][DATA_WIDTH]) ? lk2[g][DATA_WIDTH-1:0] : v2_q[g];
    end

    // ---------------- entry state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= RS_FREE;
                op_q[i]    <= '0;
                v1_q[i]    <= '0;
                v2_q[i]    <= '0;
                t1_q[i]    <= '0;
                t2_q[i]    <= '0;
            end
            r1_q          <= '0;
            r2_q          <= '0;
            locked_q      <= 1'b0;
            locked_slot_q <= '0;
        end else begin
            locked_q      <= disp_valid_o && !disp_ready_i;
            locked_slot_q <= sel_slot;
            for (int i = 0; i < DEPTH; i++) begin
                case (state_q[i])
                    RS_FREE: if (issue_fire && free_slot == SLOT_W'(i)) begin
                        op_q[i]    <= issue_op_i;
                        v1_q[i]    <= iss_v1;
                        v2_q[i]    <= iss_v2;
                        t1_q[i]    <= read1_value_i.data.prod.tag;
                        t2_q[i]    <= read2_value_i.data.prod.tag;
                        r1_q[i]    <= iss_r1;
                        r2_q[i]    <= iss_r2;
                        state_q[i] <= (iss_r1 && iss_r2) ? RS_READY : RS_WAIT;
                    end
                    RS_WAIT: begin
                        v1_q[i] <= w_v1[i];
                        v2_q[i] <= w_v2[i];
                        r1_q[i] <= w_r1[i];
                        r2_q[i] <= w_r2[i];
                        if (w_r1[i] && w_r2[i])
                            state_q[i] <= RS_READY;
                    end
                    RS_READY: if (handshake && sel_slot == SLOT_W'(i))
                        state_q[i] <= RS_EXEC;
                    RS_EXEC: if (unit_done_i && done_slot_i == SLOT_W'(i))
                        state_q[i] <= RS_DONE;
                    RS_DONE: if (retire_i && retire_slot_i == SLOT_W'(i))
                        state_q[i] <= RS_FREE;
                    default: state_q[i] <= RS_FREE;
                endcase
            end
        end
    end

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (issue_fire),
        .alloc_slot (free_slot),
        .free_en    (free_en),
        .free_slot  (retire_slot_i),
        .req        (ready_mask),
        .oldest     (oldest)
    );

endmodule

// File: tb/tb_reservation_station_pool.sv
module tb_reservation_station_pool;
    import reservation_station_pool_pkg::*;

    localparam int DW = 64, DEPTH = 4, NB = 2, SW = 2;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       issue_en_i;
    operation_specification     issue_op_i;
    tagged_register             read1_value_i, read2_value_i;
    logic                       full_o;
    rs_tag                      issue_tag_o;
    logic [NB-1:0]              bcast_en_i;
    rs_tag [NB-1:0]             bcast_tag_i;
    logic [NB-1:0][DW-1:0]      bcast_data_i;
    logic                       disp_valid_o, disp_ready_i;
    logic [SW-1:0]              disp_slot_o;
    operation_specification     disp_op_o;
    logic [DW-1:0]              disp_op1_o, disp_op2_o;
    logic                       unit_done_i;
    logic [SW-1:0]              done_slot_i;
    logic                       retire_i;
    logic [SW-1:0]              retire_slot_i;
    logic [DEPTH-1:0]           done_mask_o, busy_mask_o;

    always #5 clk = ~clk;

    reservation_station_pool #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .N_BCAST(NB), .RS_ID(ALU)) dut (
        .clk(clk), .rst(rst),
        .issue_en_i(issue_en_i), .issue_op_i(issue_op_i),
        .read1_value_i(read1_value_i), .read2_value_i(read2_value_i),
        .full_o(full_o), .issue_tag_o(issue_tag_o),
        .bcast_en_i(bcast_en_i), .bcast_tag_i(bcast_tag_i), .bcast_data_i(bcast_data_i),
        .disp_valid_o(disp_valid_o), .disp_ready_i(disp_ready_i), .disp_slot_o(disp_slot_o),
        .disp_op_o(disp_op_o), .disp_op1_o(disp_op1_o), .disp_op2_o(disp_op2_o),
        .unit_done_i(unit_done_i), .done_slot_i(done_slot_i),
        .retire_i(retire_i), .retire_slot_i(retire_slot_i),
        .done_mask_o(done_mask_o), .busy_mask_o(busy_mask_o)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    localparam int M_FREE = 0, M_WAIT = 1, M_READY = 2, M_EXEC = 3, M_DONE = 4;
    int                     m_st [DEPTH];
    operation_specification m_op [DEPTH];
    logic [63:0]            m_v1 [DEPTH], m_v2 [DEPTH];
    bit                     m_r1 [DEPTH], m_r2 [DEPTH];
    rs_tag                  m_t1 [DEPTH], m_t2 [DEPTH];
    int                     order_q [$];   // slots in issue order
    bit                     m_lock;
    int                     m_lslot;

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) m_st[i] = M_FREE;
        order_q.delete();
        m_lock = 0;
        m_lslot = 0;
    endfunction

    function automatic int m_free_slot();
        for (int i = 0; i < DEPTH; i++) if (m_st[i] == M_FREE) return i;
        return -1;
    endfunction

    function automatic int m_pick();
        if (m_lock) return m_lslot;
        foreach (order_q[k]) if (m_st[order_q[k]] == M_READY) return order_q[k];
        return -1;
    endfunction

    function automatic bit m_bc(input rs_tag t, output logic [63:0] d);
        d = '0;
        for (int c = 0; c < NB; c++)
            if (bcast_en_i[c] && bcast_tag_i[c] == t) begin
                d = bcast_data_i[c];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic void m_step();
        int cs [DEPTH];
        int fs, pk;
        logic [63:0] d;
        cs = m_st;
        fs = m_free_slot();
        pk = m_pick();
        for (int i = 0; i < DEPTH; i++) if (cs[i] == M_WAIT) begin
            if (!m_r1[i] && m_bc(m_t1[i], d)) begin m_r1[i] = 1; m_v1[i] = d; end
            if (!m_r2[i] && m_bc(m_t2[i], d)) begin m_r2[i] = 1; m_v2[i] = d; end
            if (m_r1[i] && m_r2[i]) m_st[i] = M_READY;
        end
        if (pk >= 0 && disp_ready_i) m_st[pk] = M_EXEC;
        if (unit_done_i && cs[done_slot_i] == M_EXEC) m_st[done_slot_i] = M_DONE;
        if (retire_i && cs[retire_slot_i] == M_DONE) begin
            m_st[retire_slot_i] = M_FREE;
            for (int k = 0; k < order_q.size(); k++)
                if (order_q[k] == int'(retire_slot_i)) begin order_q.delete(k); break; end
        end
        if (issue_en_i && fs >= 0) begin
            m_op[fs] = issue_op_i;
            m_t1[fs] = read1_value_i.data.prod.tag;
            m_t2[fs] = read2_value_i.data.prod.tag;
            if (!read1_value_i.is_virtual) begin m_r1[fs] = 1; m_v1[fs] = read1_value_i.data.value; end
            else m_r1[fs] = m_bc(m_t1[fs], m_v1[fs]);
            if (!read2_value_i.is_virtual) begin m_r2[fs] = 1; m_v2[fs] = read2_value_i.data.value; end
            else m_r2[fs] = m_bc(m_t2[fs], m_v2[fs]);
            m_st[fs] = (m_r1[fs] && m_r2[fs]) ? M_READY : M_WAIT;
            order_q.push_back(fs);
        end
        m_lock  = (pk >= 0) && !disp_ready_i;
        m_lslot = pk;
    endfunction

    task automatic check_all();
        int fs, pk;
        logic [3:0] eb, ed;
        fs = m_free_slot();
        pk = m_pick();
        for (int i = 0; i < DEPTH; i++) begin
            eb[i] = (m_st[i] != M_FREE);
            ed[i] = (m_st[i] == M_DONE);
        end
        chk("full", 64'(full_o), 64'(fs < 0));
        if (fs >= 0) chk("issue_tag", 64'(issue_tag_o), {58'd0, 2'd0, 4'(fs)});
        chk("disp_valid", 64'(disp_valid_o), 64'(pk >= 0));
        if (pk >= 0) begin
            chk("disp_slot", 64'(disp_slot_o), 64'(pk));
            chk("disp_op", 64'(disp_op_o), 64'(m_op[pk]));
            chk("disp_op1", disp_op1_o, m_v1[pk]);
            chk("disp_op2", disp_op2_o, m_v2[pk]);
        end else begin
            chk("disp_op1_idle", disp_op1_o, 64'd0);
        end
        chk("busy_mask", 64'(busy_mask_o), 64'(eb));
        chk("done_mask", 64'(done_mask_o), 64'(ed));
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic tagged_register tr_val(input logic [63:0] v);
        tagged_register r;
        r.is_virtual = 1'b0;
        r.data.value = v;
        return r;
    endfunction

    function automatic tagged_register tr_tag(input rs_tag t);
        tagged_register r;
        r.is_virtual = 1'b1;
        r.data.value = {$urandom, $urandom};
        r.data.prod.tag = t;
        return r;
    endfunction

    function automatic rs_tag tg(input e_functional_unit u, input int s);
        rs_tag t;
        t.unit = u;
        t.slot = 4'(s);
        return t;
    endfunction

    function automatic rs_tag rand_tag();
        return tg(($urandom_range(0, 1) == 0) ? MUL : LSU, $urandom_range(0, 1));
    endfunction

    task automatic idle();
        issue_en_i = 0; issue_op_i = '0;
        read1_value_i = tr_val(0); read2_value_i = tr_val(0);
        bcast_en_i = '0; bcast_tag_i = '0; bcast_data_i = '0;
        disp_ready_i = 0; unit_done_i = 0; done_slot_i = '0;
        retire_i = 0; retire_slot_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        m_reset();
        rst = 0;
    endtask

    task automatic issue_res(input int k);
        idle();
        issue_en_i = 1;
        issue_op_i = operation_specification'(16'(k + 1));
        read1_value_i = tr_val(5);
        read2_value_i = tr_val(7);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle();
        m_reset();
        do_reset();
        chk("rst_full", 64'(full_o), 0);
        chk("rst_valid", 64'(disp_valid_o), 0);
        chk("rst_busy", 64'(busy_mask_o), 0);
        chk("rst_done", 64'(done_mask_o), 0);
        chk("rst_tag", 64'(issue_tag_o), 0);
        chk("rst_slot", 64'(disp_slot_o), 0);
        chk("rst_op1", disp_op1_o, 0);

        // Fill with resolved ops, overflow, then drain in order.
        for (int k = 0; k < 4; k++) begin issue_res(k); tick(); end
        chk("fill_full", 64'(full_o), 1);
        issue_res(9); tick();
        chk("overflow_busy", 64'(busy_mask_o), 64'hF);
        idle(); disp_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_slot", 64'(disp_slot_o), 64'(k));
            chk("drain_op1", disp_op1_o, 5);
            chk("drain_op2", disp_op2_o, 7);
            tick();
        end
        chk("drain_empty", 64'(disp_valid_o), 0);

        // Bypass at issue from channel 1.
        do_reset();
        idle(); issue_en_i = 1;
        read1_value_i = tr_tag(tg(MUL, 2)); read2_value_i = tr_val(9);
        bcast_en_i = 2'b11;
        bcast_tag_i[0] = tg(LSU, 1); bcast_data_i[0] = 64'h55;
        bcast_tag_i[1] = tg(MUL, 2); bcast_data_i[1] = 64'hAB;
        tick();
        chk("bypass_valid", 64'(disp_valid_o), 1);
        chk("bypass_op1", disp_op1_o, 64'hAB);

        // Two channels with the same tag: channel 0 wins.
        do_reset();
        idle(); issue_en_i = 1;
        read1_value_i = tr_tag(tg(LSU, 1)); read2_value_i = tr_val(3);
        tick();
        chk("wait_valid", 64'(disp_valid_o), 0);
        idle(); bcast_en_i = 2'b11;
        bcast_tag_i[0] = tg(LSU, 1); bcast_data_i[0] = 64'd1;
        bcast_tag_i[1] = tg(LSU, 1); bcast_data_i[1] = 64'd2;
        tick();
        chk("prio_valid", 64'(disp_valid_o), 1);
        chk("prio_op1", disp_op1_o, 64'd1);

        // Locked offer on slot 2 while older slot 1 becomes READY.
        do_reset();
        idle(); issue_en_i = 1; read1_value_i = tr_tag(tg(MUL, 0)); tick();
        idle(); issue_en_i = 1; read1_value_i = tr_tag(tg(MUL, 1)); tick();
        idle(); issue_en_i = 1; read1_value_i = tr_val(64'h22); tick();
        chk("lock_first", 64'(disp_slot_o), 2);
        idle(); bcast_en_i = 2'b01; bcast_tag_i[0] = tg(MUL, 1); bcast_data_i[0] = 64'h11;
        tick();
        chk("lock_hold", 64'(disp_slot_o), 2);
        idle(); disp_ready_i = 1;
        chk("lock_accept", 64'(disp_slot_o), 2);
        tick();
        chk("lock_next", 64'(disp_slot_o), 1);
        chk("lock_next_op1", disp_op1_o, 64'h11);

        // Handshake+done same cycle, then retire+issue while full.
        do_reset();
        for (int k = 0; k < 4; k++) begin issue_res(k); tick(); end
        for (int k = 0; k < 4; k++) begin
            idle(); disp_ready_i = 1; unit_done_i = 1; done_slot_i = SW'(k);
            tick();
            chk("hs_done_ignored", 64'(done_mask_o), 0);
        end
        for (int k = 0; k < 4; k++) begin
            idle(); unit_done_i = 1; done_slot_i = SW'(k); tick();
        end
        chk("all_done", 64'(done_mask_o), 64'hF);
        issue_res(7); retire_i = 1; retire_slot_i = 2'd3;
        tick();
        chk("ret_iss_busy", 64'(busy_mask_o), 64'h7);
        chk("ret_iss_tag", 64'(issue_tag_o), 64'h03);
        issue_res(8); tick();
        chk("reissue_busy", 64'(busy_mask_o), 64'hF);

        // Async reset with three entries executing.
        do_reset();
        for (int k = 0; k < 3; k++) begin issue_res(k); tick(); end
        for (int k = 0; k < 3; k++) begin idle(); disp_ready_i = 1; tick(); end
        chk("exec_busy", 64'(busy_mask_o), 64'h7);
        idle();
        #2 rst = 1;
        #1;
        chk("arst_busy", 64'(busy_mask_o), 0);
        chk("arst_done", 64'(done_mask_o), 0);
        chk("arst_valid", 64'(disp_valid_o), 0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        idle(); unit_done_i = 1; done_slot_i = 2'd0;
        tick();
        chk("late_done", 64'(done_mask_o), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            idle();
            issue_en_i = ($urandom_range(0, 1) == 1);
            issue_op_i = operation_specification'(16'($urandom));
            read1_value_i = ($urandom_range(0, 1) == 1) ? tr_tag(rand_tag()) : tr_val({$urandom, $urandom});
            read2_value_i = ($urandom_range(0, 1) == 1) ? tr_tag(rand_tag()) : tr_val({$urandom, $urandom});
            for (int c = 0; c < NB; c++) begin
                bcast_en_i[c]   = ($urandom_range(0, 2) == 0);
                bcast_tag_i[c]  = rand_tag();
                bcast_data_i[c] = {$urandom, $urandom};
            end
            disp_ready_i  = ($urandom_range(0, 1) == 1);
            unit_done_i   = ($urandom_range(0, 1) == 1);
            done_slot_i   = SW'($urandom_range(0, DEPTH - 1));
            retire_i      = ($urandom_range(0, 1) == 1);
            retire_slot_i = SW'($urandom_range(0, DEPTH - 1));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
